vehicle_detector: RTL and testbench

Producer end of the `sensor` interface into the traffic-light controller. It conditions the raw country-road loop detector into a clean, latched `sensor` request and holds the request until the controller actually serves the country road. It also exports a waiting-time counter, an urgency flag and a queue count. It sits beside `main_control` and shares its `clk`, `rst_n` and 1-second `pulse`, and it observes `countryroad_led` as the grant indication.

---
 rtl/vehicle_detector.sv | 154 +++++++++++++++
 tb/tb_vehicle_detector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_detector.sv
// Country-road vehicle detector: synchronizes and debounces the loop detector and
// holds a latched request to the traffic-light controller until green serves it.
module vehicle_detector #(
    parameter int unsigned DEBOUNCE = 4,
    parameter logic [5:0]  MAX_WAIT = 6'd20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_in,
    input  logic       pulse,
    input  logic [2:0] countryroad_led,
    output logic       sensor,
    output logic       urgent,
    output logic [5:0] wait_sec,
    output logic [3:0] queue_cnt,
    output logic [1:0] dbg_state,
    output logic       dbg_loop_db
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SERVED  = 2'd2
    } state_t;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE);

    logic       green, yellow, red;
    logic       arr;

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic [7:0] db_cnt_q, db_cnt_d;
    logic       loop_db_q, loop_db_d;
    logic       loop_db_prev_q, loop_db_prev_d;
    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic       sensor_q, sensor_d;
    logic       urgent_q, urgent_d;
    logic [5:0] wait_sec_q, wait_sec_d;
    logic [3:0] queue_cnt_q, queue_cnt_d;

    assign green  = countryroad_led[0];
    assign yellow = countryroad_led[1];
    assign red    = countryroad_led[2];

    // Synchronizer and debouncer: the debounced level only moves after the
    // synchronized level has disagreed with it for DEBOUNCE consecutive edges.
    always_comb begin
        s1_d           = loop_in;
        s2_d           = s1_q;
        loop_db_d      = loop_db_q;
        db_cnt_d       = '0;
        loop_db_prev_d = loop_db_q;
        if (s2_q != loop_db_q) begin
            if (db_cnt_q + 8'd1 == DB_LIMIT) begin
                loop_db_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 8'd1;
            end
        end
    end

    assign arr = loop_db_q & ~loop_db_prev_q;

    // Request protocol: sensor is a level request, raised on an arrival outside
    // green and held until the controller shows green (the grant); no other ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arr && !green) begin
                    state_d = WAITING;
                end
            end
            WAITING: begin
                if (green) begin
                    state_d = SERVED;
                end
            end
            SERVED: begin
                if (red) begin
                    state_d = (pend_q || loop_db_q) ? WAITING : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A vehicle arriving on yellow missed the green and must re-request.
    always_comb begin
        pend_d = 1'b0;
        if (state_q == SERVED && state_d == SERVED) begin
            pend_d = pend_q | (arr & yellow);
        end
    end

    always_comb begin
        sensor_d = (state_d == WAITING);

        wait_sec_d = '0;
        if (state_q == WAITING && state_d == WAITING) begin
            wait_sec_d = wait_sec_q;
            if (pulse && wait_sec_q != 6'd63) begin
                wait_sec_d = wait_sec_q + 6'd1;
            end
        end

        urgent_d = (state_d == WAITING) && (wait_sec_q >= MAX_WAIT);

        queue_cnt_d = queue_cnt_q;
        if (state_q == WAITING && state_d == SERVED) begin
            queue_cnt_d = '0;
        end else if (arr && !green && queue_cnt_q != 4'd15) begin
            queue_cnt_d = queue_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            db_cnt_q       <= '0;
            loop_db_q      <= 1'b0;
            loop_db_prev_q <= 1'b0;
            state_q        <= IDLE;
            pend_q         <= 1'b0;
            sensor_q       <= 1'b0;
            urgent_q       <= 1'b0;
            wait_sec_q     <= '0;
            queue_cnt_q    <= '0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            db_cnt_q       <= db_cnt_d;
            loop_db_q      <= loop_db_d;
            loop_db_prev_q <= loop_db_prev_d;
            state_q        <= state_d;
            pend_q         <= pend_d;
            sensor_q       <= sensor_d;
            urgent_q       <= urgent_d;
            wait_sec_q     <= wait_sec_d;
            queue_cnt_q    <= queue_cnt_d;
        end
    end

    assign sensor      = sensor_q;
    assign urgent      = urgent_q;
    assign wait_sec    = wait_sec_q;
    assign queue_cnt   = queue_cnt_q;
    assign dbg_state   = state_q;
    assign dbg_loop_db = loop_db_q;

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector: a vector table for reset, debounce and service,
// then hand-written sequences for glitches, urgency, pending re-request and saturation.
module tb_vehicle_detector;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loop_in = 1'b0;
    logic       pulse = 1'b0;
    logic [2:0] countryroad_led = RED;
    logic       sensor;
    logic       urgent;
    logic [5:0] wait_sec;
    logic [3:0] queue_cnt;
    logic [1:0] dbg_state;
    logic       dbg_loop_db;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst_n;
        logic       loop_in;
        logic       pulse;
        logic [2:0] led;
        logic       sensor;
        logic       urgent;
        logic [5:0] wait_sec;
        logic [3:0] queue_cnt;
    } vec_t;

    vec_t vecs[14];

    vehicle_detector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .loop_in         (loop_in),
        .pulse           (pulse),
        .countryroad_led (countryroad_led),
        .sensor          (sensor),
        .urgent          (urgent),
        .wait_sec        (wait_sec),
        .queue_cnt       (queue_cnt),
        .dbg_state       (dbg_state),
        .dbg_loop_db     (dbg_loop_db)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One debounced arrival: high long enough to register, low long enough to clear.
    task automatic arrive();
        loop_in = 1'b1;
        repeat (8) tick();
        loop_in = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        loop_in = 1'b0;
        pulse = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // rst_n, loop_in, pulse, led | sensor, urgent, wait_sec, queue_cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, RED,    1'b0, 1'b0, 6'd0, 4'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, RED,    1'b1, 1'b0, 6'd0, 4'd1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, RED,    1'b1, 1'b0, 6'd1, 4'd1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, RED,    1'b1, 1'b0, 6'd1, 4'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, GREEN,  1'b0, 1'b0, 6'd0, 4'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, GREEN,  1'b0, 1'b0, 6'd0, 4'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, YELLOW, 1'b0, 1'b0, 6'd0, 4'd0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, RED,    1'b1, 1'b0, 6'd0, 4'd0};

        for (int i = 0; i < 14; i++) begin
            rst_n           = vecs[i].rst_n;
            loop_in         = vecs[i].loop_in;
            pulse           = vecs[i].pulse;
            countryroad_led = vecs[i].led;
            tick();
            check($sformatf("vec%0d sensor", i), sensor, vecs[i].sensor);
            check($sformatf("vec%0d urgent", i), urgent, vecs[i].urgent);
            check($sformatf("vec%0d wait_sec", i), wait_sec, vecs[i].wait_sec);
            check($sformatf("vec%0d queue_cnt", i), queue_cnt, vecs[i].queue_cnt);
        end

        // Reset in the middle of a request.
        pulse = 1'b1;
        repeat (7) tick();
        pulse = 1'b0;
        check("pre_reset wait_sec", wait_sec, 7);
        check("pre_reset sensor", sensor, 1);
        rst_n = 1'b0;
        loop_in = 1'b0;
        tick();
        check("reset sensor", sensor, 0);
        check("reset urgent", urgent, 0);
        check("reset wait_sec", wait_sec, 0);
        check("reset queue_cnt", queue_cnt, 0);
        check("reset state", dbg_state, 0);
        check("reset loop_db", dbg_loop_db, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset sensor", sensor, 0);
            check("post_reset queue_cnt", queue_cnt, 0);
        end

        // A 3-cycle glitch never reaches the debounced level.
        loop_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) loop_in = 1'b0;
            tick();
            check("glitch loop_db", dbg_loop_db, 0);
            check("glitch sensor", sensor, 0);
            check("glitch queue_cnt", queue_cnt, 0);
        end

        // A 5-cycle pulse is long enough to register as an arrival.
        loop_in = 1'b1;
        repeat (5) tick();
        loop_in = 1'b0;
        tick();
        check("pulse5 sensor_early", sensor, 0);
        repeat (9) tick();
        check("pulse5 sensor", sensor, 1);
        check("pulse5 queue_cnt", queue_cnt, 1);
        check("pulse5 wait_sec", wait_sec, 0);
        check("pulse5 loop_db_fell", dbg_loop_db, 0);

        // Urgency after MAX_WAIT ticks, then saturation at 63.
        for (int i = 0; i < 19; i++) begin
            pulse = 1'b1;
            tick();
            pulse = 1'b0;
            tick();
        end
        check("wait19 wait_sec", wait_sec, 19);
        check("wait19 urgent", urgent, 0);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        check("wait20 wait_sec", wait_sec, 20);
        check("wait20 urgent", urgent, 0);
        tick();
        check("urgent_rise", urgent, 1);
        check("urgent_rise wait_sec", wait_sec, 20);
        pulse = 1'b1;
        repeat (43) tick();
        check("wait63 wait_sec", wait_sec, 63);
        tick();
        pulse = 1'b0;
        check("wait_sat wait_sec", wait_sec, 63);
        check("wait_sat urgent", urgent, 1);

        // Service with three queued vehicles, then a yellow arrival re-requests.
        arrive();
        arrive();
        check("queue3 queue_cnt", queue_cnt, 3);
        check("queue3 sensor", sensor, 1);
        countryroad_led = GREEN;
        tick();
        check("grant sensor", sensor, 0);
        check("grant urgent", urgent, 0);
        check("grant wait_sec", wait_sec, 0);
        check("grant queue_cnt", queue_cnt, 0);
        check("grant state", dbg_state, 2);
        countryroad_led = YELLOW;
        tick();
        arrive();
        check("yellow_arr sensor", sensor, 0);
        check("yellow_arr queue_cnt", queue_cnt, 1);
        countryroad_led = RED;
        tick();
        check("rerequest sensor", sensor, 1);
        check("rerequest state", dbg_state, 1);

        // Arrivals during green pass through without a request.
        do_reset();
        countryroad_led = GREEN;
        for (int i = 0; i < 2; i++) begin
            arrive();
            check("green_pass sensor", sensor, 0);
            check("green_pass queue_cnt", queue_cnt, 0);
            check("green_pass state", dbg_state, 0);
        end

        // Seventeen arrivals on red saturate the queue count.
        countryroad_led = RED;
        arrive();
        check("sat first sensor", sensor, 1);
        check("sat first queue_cnt", queue_cnt, 1);
        for (int i = 1; i < 15; i++) arrive();
        check("sat15 queue_cnt", queue_cnt, 15);
        arrive();
        check("sat16 queue_cnt", queue_cnt, 15);
        arrive();
        check("sat17 queue_cnt", queue_cnt, 15);

        // Arrival on the same edge as the grant: the clear wins.
        loop_in = 1'b1;
        repeat (6) tick();
        check("arr_on_grant loop_db", dbg_loop_db, 1);
        countryroad_led = GREEN;
        tick();
        check("arr_on_grant queue_cnt", queue_cnt, 0);
        check("arr_on_grant sensor", sensor, 0);
        check("arr_on_grant state", dbg_state, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
